imem_loader: RTL and testbench

Front-panel program loader for the SMP8 board: the write side of the 16x8 instruction memory that the processor reads. It holds its own 16-entry x 8-bit register array, which replaces `imem` in the top level. An operator enters instructions on 8 slide switches and commits each one with a debounced push-button. A second debounced button toggles between loading and running. While loading, the block holds the CPU in reset; while running, it serves the CPU's instruction fetches.

---
 rtl/imem_loader_if.sv | 11 +
 rtl/imem_loader.sv | 152 +++++++++++++++
 tb/tb_imem_loader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: instruction fetch port between the CPU and the loader-owned
// instruction memory.
//   rd_addr : CPU fetch address (pc), driven by the CPU side (master)
//   rd_data : instruction at rd_addr, driven combinationally by the memory (slave)
interface imem_loader_if;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;

  modport master (output rd_addr, input rd_data);
  modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: front-panel program loader and 16x8 instruction memory for SMP8.
// An operator enters an instruction on sw_i and commits it with the debounced
// write button; the debounced run button toggles between LOAD (CPU held in
// reset) and RUN (CPU fetches through fetch_if).
//
// Ports:
//   clk_i        : single rising-edge clock
//   reset_ni     : synchronous active-low reset
//   sw_i         : instruction value to write (quasi-static, not synchronized)
//   btn_write_i  : raw write button, active-high, asynchronous, may bounce
//   btn_run_i    : raw run/load toggle button, active-high, asynchronous, may bounce
//   fetch_if     : CPU fetch port (rd_addr in, rd_data out, combinational read)
//   cpu_run_o    : 1 = CPU may run, 0 = CPU held in reset
//   wr_addr_o    : next load address (for the display)
//   wr_pulse_o   : one-cycle strobe marking a committed write
//
// Configuration macro IMEM_LOADER_CLEAR_EN: when defined, reset also clears all
// 16 memory entries; when undefined, memory contents survive reset.
module imem_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic [7:0]    sw_i,
  input  logic          btn_write_i,
  input  logic          btn_run_i,
  imem_loader_if.slave  fetch_if,
  output logic          cpu_run_o,
  output logic [3:0]    wr_addr_o,
  output logic          wr_pulse_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  // Button index 0 = write, 1 = run.
  logic [1:0]            btn_raw;
  logic [1:0]            s1_q, s2_q;
  logic [1:0]            stable_q, stable_d;
  logic [1:0]            prev_q;
  logic [1:0]            pulse_q;
  logic [1:0][CntW-1:0]  cnt_q, cnt_d;

  assign btn_raw = {btn_run_i, btn_write_i};

  // Debounce: count consecutive samples that disagree with the accepted level;
  // any sample agreeing with it restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int b = 0; b < 2; b++) begin
      if (s2_q[b] != stable_q[b]) begin
        if (cnt_q[b] == CntMax) begin
          stable_d[b] = s2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      prev_q   <= '0;
      pulse_q  <= '0;
    end else begin
      s1_q     <= btn_raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      prev_q   <= stable_q;
      // Registered rising-edge detect: one pulse per accepted press.
      pulse_q  <= stable_q & ~prev_q;
    end
  end

  logic wp, rp;
  assign wp = pulse_q[0];
  assign rp = pulse_q[1];

  // Load/run control FSM.
  typedef enum logic [0:0] {StLoad, StRun} state_e;

  state_e     state_q, state_d;
  logic [3:0] wr_addr_q, wr_addr_d;
  logic       mem_we;

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    mem_we    = 1'b0;
    unique case (state_q)
      StLoad: begin
        // A write landing with a run press still commits before entering RUN.
        if (wp) begin
          mem_we    = 1'b1;
          wr_addr_d = wr_addr_q + 4'd1;
        end
        if (rp) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (rp) begin
          state_d   = StLoad;
          wr_addr_d = 4'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q   <= StLoad;
      wr_addr_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  // Instruction memory.
  logic [7:0] mem_q [16];

  always_ff @(posedge clk_i) begin
`ifdef IMEM_LOADER_CLEAR_EN
    if (!reset_ni) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (mem_we) begin
      mem_q[wr_addr_q] <= sw_i;
    end
`else
    // Contents are kept across reset so a loaded program survives it.
    if (reset_ni && mem_we) begin
      mem_q[wr_addr_q] <= sw_i;
    end
`endif
  end

  assign fetch_if.rd_data = mem_q[fetch_if.rd_addr];

  assign cpu_run_o  = (state_q == StRun);
  assign wr_addr_o  = wr_addr_q;
  assign wr_pulse_o = mem_we;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with DEBOUNCE_CYCLES = 4. Expected writes are
// queued when a write press is driven and checked when wr_pulse_o appears.
module tb_imem_loader;

  localparam int unsigned Deb = 4;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_w, btn_r;
  logic [7:0] sw;
  logic       cpu_run_o;
  logic [3:0] wr_addr_o;
  logic       wr_pulse_o;

  always #5 clk = ~clk;

  imem_loader_if fetch_if();

  imem_loader #(
    .DEBOUNCE_CYCLES (Deb)
  ) dut (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .sw_i        (sw),
    .btn_write_i (btn_w),
    .btn_run_i   (btn_r),
    .fetch_if    (fetch_if.slave),
    .cpu_run_o   (cpu_run_o),
    .wr_addr_o   (wr_addr_o),
    .wr_pulse_o  (wr_pulse_o)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] addr_m;
  logic [7:0] mem_m [16];
  wr_t        sb_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_write(input logic [7:0] d);
    wr_t e;
    e.addr = addr_m;
    e.data = d;
    sb_q.push_back(e);
    addr_m = addr_m + 4'd1;
  endtask

  // Advance n cycles, sampling at each falling edge; pop the scoreboard on
  // every write strobe.
  task automatic step(input int n, output int pulses, output int first);
    wr_t e;
    pulses = 0;
    first  = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (wr_pulse_o) begin
        pulses++;
        if (first < 0) first = i;
        chk("sb_expected_write", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("sb_wr_addr", 32'(wr_addr_o), 32'(e.addr));
          mem_m[e.addr] = e.data;
        end
      end
    end
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] e);
    fetch_if.rd_addr = a;
    #1;
    chk(tag, 32'(fetch_if.rd_data), 32'(e));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    addr_m  = 4'd0;
    sb_q.delete();
`ifdef IMEM_LOADER_CLEAR_EN
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
`endif
  endtask

  initial begin
    int p, f, tot;
    reset_n = 1'b0;
    btn_w = 1'b0;
    btn_r = 1'b0;
    sw = 8'h00;
    fetch_if.rd_addr = 4'd0;
    addr_m = 4'd0;
    @(negedge clk);

    // Reset state
    do_reset();
    chk("rst_cpu_run", 32'(cpu_run_o), 0);
    chk("rst_wr_addr", 32'(wr_addr_o), 0);
    chk("rst_wr_pulse", 32'(wr_pulse_o), 0);
`ifdef IMEM_LOADER_CLEAR_EN
    for (int a = 0; a < 16; a++) rd_chk("rst_clear", 4'(a), 8'h00);
`endif

    // Single held press: pulse after E6, commit at E7, no repeat while held
    sw = 8'hA5;
    push_write(8'hA5);
    btn_w = 1'b1;
    step(100, p, f);
    chk("a_first_pulse", f, 6);
    chk("a_pulse_count", p, 1);
    chk("a_wr_addr", 32'(wr_addr_o), 1);
    rd_chk("a_mem0", 4'd0, 8'hA5);
    btn_w = 1'b0;
    step(10, p, f);
    chk("a_release_pulses", p, 0);

    // Reset keeps or clears memory depending on configuration
    do_reset();
    chk("persist_wr_addr", 32'(wr_addr_o), 0);
    chk("persist_cpu_run", 32'(cpu_run_o), 0);
`ifdef IMEM_LOADER_CLEAR_EN
    rd_chk("persist_mem0", 4'd0, 8'h00);
`else
    rd_chk("persist_mem0", 4'd0, 8'hA5);
`endif

    // Bounce 3 high / 1 low for 40 cycles, then hold
    sw = 8'h5A;
    tot = 0;
    for (int k = 0; k < 10; k++) begin
      btn_w = 1'b1;
      step(3, p, f);
      tot += p;
      btn_w = 1'b0;
      step(1, p, f);
      tot += p;
    end
    chk("b_bounce_pulses", tot, 0);
    push_write(8'h5A);
    btn_w = 1'b1;
    step(20, p, f);
    chk("b_hold_pulses", p, 1);
    chk("b_hold_first", f, 6);
    rd_chk("b_mem0", 4'd0, 8'h5A);
    btn_w = 1'b0;
    step(10, p, f);

    // 17 writes wrap the load address
    do_reset();
    for (int k = 0; k < 17; k++) begin
      sw = 8'(8'h10 + k);
      push_write(sw);
      btn_w = 1'b1;
      step(8, p, f);
      chk("c_press_pulses", p, 1);
      btn_w = 1'b0;
      step(8, p, f);
    end
    chk("c_wr_addr", 32'(wr_addr_o), 1);
    for (int a = 0; a < 16; a++) begin
      rd_chk("c_mem", 4'(a), (a == 0) ? 8'h20 : 8'(8'h10 + a));
    end

    // Write and run pulses in the same cycle
    do_reset();
    for (int k = 0; k < 2; k++) begin
      sw = 8'(8'hE0 + k);
      push_write(sw);
      btn_w = 1'b1;
      step(8, p, f);
      btn_w = 1'b0;
      step(8, p, f);
    end
    chk("d_pre_wr_addr", 32'(wr_addr_o), 2);
    sw = 8'h3C;
    push_write(8'h3C);
    btn_w = 1'b1;
    btn_r = 1'b1;
    step(10, p, f);
    chk("d_both_pulses", p, 1);
    chk("d_both_first", f, 6);
    chk("d_both_wr_addr", 32'(wr_addr_o), 3);
    chk("d_both_cpu_run", 32'(cpu_run_o), 1);
    rd_chk("d_mem2", 4'd2, 8'h3C);
    btn_w = 1'b0;
    btn_r = 1'b0;
    step(10, p, f);

    // Write press in RUN is ignored
    sw = 8'hFF;
    btn_w = 1'b1;
    step(10, p, f);
    chk("d_run_wr_pulses", p, 0);
    btn_w = 1'b0;
    step(10, p, f);
    chk("d_run_wr_addr", 32'(wr_addr_o), 3);
    chk("d_run_cpu_run", 32'(cpu_run_o), 1);
    rd_chk("d_run_mem2", 4'd2, 8'h3C);
    rd_chk("d_run_mem3", 4'd3, mem_m[3]);

    // Run press returns to LOAD with address cleared
    btn_r = 1'b1;
    step(10, p, f);
    chk("d_load_cpu_run", 32'(cpu_run_o), 0);
    chk("d_load_wr_addr", 32'(wr_addr_o), 0);
    btn_r = 1'b0;
    step(10, p, f);

    // Reset mid-debounce on run button while held
    btn_r = 1'b1;
    step(3, p, f);
    do_reset();
    f = -1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (cpu_run_o && f < 0) f = i;
    end
    chk("e_run_first", f, 7);
    step(30, p, f);
    chk("e_run_held", 32'(cpu_run_o), 1);
    btn_r = 1'b0;
    step(10, p, f);
    chk("e_no_writes", p, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
